analog_tx: RTL and testbench

- Downstream neighbour of the analog RX stage; closes the loop from the analog Ising macro back to the digital side.
- Waits for the macro's compute-finish indication, then lets the analog spin outputs settle for a programmable number of cycles.
- Samples and masks the spin vector, then offers it to the digital spin buffer over a valid/ready push interface.
- Reports idle status and a sticky overrun flag when a compute-finish arrives while a previous sample is still pending.

---
 rtl/analog_tx_pkg.sv | 19 +
 rtl/step_counter.sv | 41 ++++
 rtl/analog_tx.sv | 165 ++++++++++++++++
 tb/tb_analog_tx.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/analog_tx_pkg.sv
// Shared types and helpers for the analog TX sampler (analog_tx).
package analog_tx_pkg;

    localparam int unsigned NUM_SPIN_DEF         = 256;
    localparam int unsigned COUNTER_BITWIDTH_DEF = 8;

    // Sampler state: wait for finish edge, let outputs settle, offer sample.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        PUSH   = 2'd2
    } tx_state_e;

    // Bits needed to count 0..n flipped spins.
    function automatic int unsigned flip_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/step_counter.sv
// Programmable down-counter: holds a period, restarts from it on recount,
// decrements on step and flags the step taken at zero (the overflow cycle).
module step_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             clear_i,
    input  logic             recount_i,
    input  logic             step_i,
    output logic             overflow_c_o
);

    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] count_q;

    // Period register and running count; clear wins over recount and step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_q <= '0;
            count_q  <= '0;
        end else begin
            if (load_i) begin
                period_q <= load_value_i;
            end
            if (clear_i) begin
                count_q <= '0;
            end else if (recount_i) begin
                count_q <= period_q;
            end else if (step_i && (count_q != '0)) begin
                count_q <= count_q - WIDTH'(1);
            end
        end
    end

    // A step taken while already at zero ends the count.
    assign overflow_c_o = step_i && (count_q == '0);

endmodule

// File: rtl/analog_tx.sv
// Analog TX sampler: on a compute-finish rising edge, waits a programmable
// number of settle cycles, captures the masked analog spin vector and offers
// it downstream over valid/ready. Flags finish edges dropped while busy.
// Optional feature macro: ANALOG_TX_FLIP_COUNT_EN adds flip_count_o, the
// number of spins that differ from the previously pushed vector.
module analog_tx
    import analog_tx_pkg::*;
#(
    parameter int unsigned num_spin         = NUM_SPIN_DEF,
    parameter int unsigned counter_bitwidth = COUNTER_BITWIDTH_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic                        tx_configure_enable_i,
    input  logic [counter_bitwidth-1:0] cycle_per_sample_i,
    input  logic [num_spin-1:0]         spin_mask_i,
    input  logic                        analog_macro_cmpt_finish_i,
    input  logic [num_spin-1:0]         spin_analog_i,
    output logic                        spin_push_valid_o,
    input  logic                        spin_push_ready_i,
    output logic [num_spin-1:0]         spin_push_o,
    output logic                        analog_tx_idle_o,
    output logic                        sample_overrun_o
`ifdef ANALOG_TX_FLIP_COUNT_EN
    ,
    output logic [flip_cnt_width(num_spin)-1:0] flip_count_o
`endif
);

    tx_state_e             state_q;
    logic                  finish_q;
    logic                  idle_q;
    logic                  valid_q;
    logic                  overrun_q;
    logic [num_spin-1:0]   mask_q;
    logic [num_spin-1:0]   data_q;
    logic                  start_c;
    logic                  capture_c;
    logic                  cfg_load_c;
    logic [num_spin-1:0]   sampled_c;

    assign start_c    = en_i && analog_macro_cmpt_finish_i && !finish_q;
    assign cfg_load_c = en_i && tx_configure_enable_i && (state_q == IDLE);
    assign sampled_c  = spin_analog_i & mask_q;

    // Settle-cycle counter; its overflow marks the capture cycle.
    step_counter #(
        .WIDTH (counter_bitwidth)
    ) u_settle_cnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (cfg_load_c),
        .load_value_i (cycle_per_sample_i),
        .clear_i      (!en_i),
        .recount_i    (start_c && (state_q == IDLE)),
        .step_i       (en_i && (state_q == SETTLE)),
        .overflow_c_o (capture_c)
    );

    // Finish-edge tracker: follows the input even while disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            finish_q <= 1'b0;
        end else begin
            finish_q <= analog_macro_cmpt_finish_i;
        end
    end

    // Sampler FSM with registered status, data and overrun outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idle_q    <= 1'b1;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            mask_q    <= '0;
            data_q    <= '0;
        end else if (!en_i) begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_configure_enable_i) begin
                        mask_q    <= spin_mask_i;
                        overrun_q <= 1'b0;
                    end
                    if (start_c) begin
                        state_q <= SETTLE;
                        idle_q  <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (start_c) begin
                        overrun_q <= 1'b1;
                    end
                    if (capture_c) begin
                        data_q  <= sampled_c;
                        valid_q <= 1'b1;
                        state_q <= PUSH;
                    end
                end
                PUSH: begin
                    if (start_c) begin
                        overrun_q <= 1'b1;
                    end
                    if (spin_push_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idle_q  <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign spin_push_valid_o = valid_q;
    assign spin_push_o       = data_q;
    assign analog_tx_idle_o  = idle_q;
    assign sample_overrun_o  = overrun_q;

`ifdef ANALOG_TX_FLIP_COUNT_EN
    localparam int unsigned FLIP_W = flip_cnt_width(num_spin);

    logic [num_spin-1:0] last_q;
    logic [FLIP_W-1:0]   flip_q;
    logic [num_spin-1:0] diff_c;
    logic [FLIP_W-1:0]   popcnt_c;

    assign diff_c = sampled_c ^ last_q;

    // Number of spins that changed against the last pushed vector.
    always_comb begin
        popcnt_c = '0;
        for (int unsigned i = 0; i < num_spin; i++) begin
            popcnt_c = popcnt_c + FLIP_W'(diff_c[i]);
        end
    end

    // Last pushed vector and flip count, registered alongside the sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= '0;
            flip_q <= '0;
        end else if (en_i) begin
            if ((state_q == SETTLE) && capture_c) begin
                flip_q <= popcnt_c;
            end
            if ((state_q == PUSH) && spin_push_ready_i) begin
                last_q <= data_q;
            end
        end
    end

    assign flip_count_o = flip_q;
`endif

endmodule

// File: tb/tb_analog_tx.sv
// Randomized scoreboard bench for analog_tx: stimulus pushes expected samples,
// a negedge monitor checks them when the DUT presents valid data.
module tb_analog_tx;

    localparam int unsigned NS = 256;
    localparam int unsigned CW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            cfg = 1'b0;
    logic [CW-1:0]   cps = '0;
    logic [NS-1:0]   mask = '0;
    logic            fin = 1'b0;
    logic [NS-1:0]   spin = '0;
    logic            valid;
    logic            ready = 1'b0;
    logic [NS-1:0]   push;
    logic            idle;
    logic            overrun;
`ifdef ANALOG_TX_FLIP_COUNT_EN
    localparam int unsigned FW = $clog2(NS + 1);
    logic [FW-1:0]   flip;
`endif

    analog_tx #(
        .num_spin         (NS),
        .counter_bitwidth (CW)
    ) dut (
        .clk_i                      (clk),
        .rst_ni                     (rst_n),
        .en_i                       (en),
        .tx_configure_enable_i      (cfg),
        .cycle_per_sample_i         (cps),
        .spin_mask_i                (mask),
        .analog_macro_cmpt_finish_i (fin),
        .spin_analog_i              (spin),
        .spin_push_valid_o          (valid),
        .spin_push_ready_i          (ready),
        .spin_push_o                (push),
        .analog_tx_idle_o           (idle),
        .sample_overrun_o           (overrun)
`ifdef ANALOG_TX_FLIP_COUNT_EN
        ,
        .flip_count_o               (flip)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NS-1:0] data;
        int            flip;
        int            vcyc;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            failures = 0;
    int            hs_count = 0;

    // Reference model state
    int            n_m = 0;
    logic [NS-1:0] mask_m = '0;
    logic [NS-1:0] last_m = '0;
    bit            overrun_m = 1'b0;

    task automatic chk(string name, logic [NS-1:0] act, logic [NS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NS-1:0] rand_vec();
        logic [NS-1:0] v;
        for (int i = 0; i < int'(NS / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: sample away from the active edge and pop on handshake.
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            valid_prev = 1'b0;
        end else begin
            if (valid && !valid_prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("valid_cycle", NS'(cyc), NS'(q[0].vcyc));
`ifdef ANALOG_TX_FLIP_COUNT_EN
                    chk("flip_count", NS'(flip), NS'(q[0].flip));
`endif
                end
            end
            if (valid && q.size() > 0) begin
                chk("push_data", push, q[0].data);
                if (ready) begin
                    void'(q.pop_front());
                    hs_count++;
                end
            end
            valid_prev = valid;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic configure(int n, logic [NS-1:0] m);
        en = 1'b1; cfg = 1'b1; cps = CW'(n); mask = m;
        tick(1);
        cfg = 1'b0;
        n_m = n; mask_m = m; overrun_m = 1'b0;
    endtask

    // Raise finish (must currently be low); model the sample if one is due.
    task automatic fire(logic [NS-1:0] s, bit expect_sample);
        exp_t e;
        spin = s;
        fin = 1'b1;
        if (expect_sample) begin
            e.data = s & mask_m;
            e.flip = $countones(e.data ^ last_m);
            e.vcyc = cyc + 2 + n_m;
            last_m = e.data;
            q.push_back(e);
        end
    endtask

    task automatic wait_done(string name, int budget, bit rand_ready);
        int k = 0;
        while (!(q.size() == 0 && idle) && k < budget) begin
            if (rand_ready) ready = 1'($urandom_range(0, 1));
            tick(1);
            k++;
        end
        checks++;
        if (k >= budget) begin
            failures++;
            $display("FAIL %s timeout actual_pending=%0d required=0", name, q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NS-1:0] v;
        int hs_before;

        // Reset state
        tick(3);
        chk("rst_valid", valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_overrun", overrun, 0);
        chk("rst_data", push, 0);
`ifdef ANALOG_TX_FLIP_COUNT_EN
        chk("rst_flip", flip, 0);
`endif
        rst_n = 1'b1;
        tick(2);

        // Basic sample, N=3
        configure(3, '1);
        ready = 1'b1;
        tick(2);
        fire({32{8'hA5}}, 1);
        wait_done("basic", 40, 0);
        chk("basic_idle", idle, 1);
        chk("basic_valid_low", valid, 0);
        fin = 1'b0;
        tick(1);

        // Mask and N=0
        configure(0, NS'(8'h0F));
        tick(1);
        fire('1, 1);
        wait_done("mask_n0", 20, 0);
        chk("mask_hold", push, NS'(8'h0F));
        fin = 1'b0;
        tick(1);

        // Backpressure with toggling analog input
        configure(2, '1);
        ready = 1'b0;
        tick(1);
        fire(rand_vec(), 1);
        tick(5);
        for (int i = 0; i < 20; i++) begin
            spin = rand_vec();
            tick(1);
        end
        chk("bp_valid_held", valid, 1);
        hs_before = hs_count;
        ready = 1'b1;
        tick(1);
        chk("bp_valid_drop", valid, 0);
        chk("bp_idle", idle, 1);
        tick(5);
        chk("bp_one_handshake", NS'(hs_count), NS'(hs_before + 1));
        fin = 1'b0;
        tick(1);

        // Overrun during PUSH, sticky until config
        configure(1, '1);
        ready = 1'b0;
        tick(1);
        fire(rand_vec(), 1);
        tick(5);
        fin = 1'b0;
        tick(1);
        fin = 1'b1;
        tick(1);
        overrun_m = 1'b1;
        chk("ovr_set", overrun, overrun_m);
        ready = 1'b1;
        wait_done("ovr_drain", 20, 0);
        tick(3);
        chk("ovr_sticky", overrun, overrun_m);
        fin = 1'b0;
        configure(1, '1);
        chk("ovr_cleared", overrun, overrun_m);

        // Handshake and new start on the same edge
        ready = 1'b0;
        tick(1);
        fire(rand_vec(), 1);
        tick(4);
        fin = 1'b0;
        tick(1);
        fin = 1'b1;
        ready = 1'b1;
        tick(1);
        overrun_m = 1'b1;
        chk("simul_idle", idle, 1);
        chk("simul_valid", valid, 0);
        chk("simul_overrun", overrun, overrun_m);
        tick(5);
        chk("simul_no_sample", idle, 1);
        fin = 1'b0;
        tick(1);

        // Abort during SETTLE, re-enable with finish still high
        configure(10, '1);
        chk("abort_cfg_clear", overrun, overrun_m);
        tick(1);
        fire(rand_vec(), 0);
        tick(3);
        chk("abort_busy", idle, 0);
        en = 1'b0;
        tick(1);
        chk("abort_idle", idle, 1);
        chk("abort_valid", valid, 0);
        chk("abort_data_kept", push, last_m);
        en = 1'b1;
        tick(15);
        chk("abort_no_retrigger", idle, 1);
        chk("abort_no_valid", valid, 0);
        fin = 1'b0;
        tick(1);

        // Flip-count pattern: zero then 0x07
        configure(0, '1);
        tick(1);
        fire('0, 1);
        wait_done("flip0", 20, 0);
        fin = 1'b0;
        tick(1);
        fire(NS'(8'h07), 1);
        wait_done("flip7", 20, 0);
`ifdef ANALOG_TX_FLIP_COUNT_EN
        chk("flip_three", flip, 3);
`endif
        fin = 1'b0;
        tick(1);

        // Randomized transactions with random backpressure and overruns
        for (int it = 0; it < 30; it++) begin
            configure(int'($urandom_range(0, 6)), ($urandom_range(0, 1) != 0) ? '1 : rand_vec());
            ready = 1'b0;
            tick(1);
            fire(rand_vec(), 1);
            if ($urandom_range(0, 2) == 0) begin
                tick(1);
                fin = 1'b0;
                tick(1);
                fin = 1'b1;
                tick(1);
                overrun_m = 1'b1;
            end
            wait_done("rand_txn", 200, 1);
            chk("rand_overrun", overrun, overrun_m);
            fin = 1'b0;
            tick(1);
        end

        // Asynchronous reset mid-operation
        configure(5, '1);
        ready = 1'b1;
        tick(1);
        fire(rand_vec(), 0);
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_idle", idle, 1);
        chk("arst_overrun", overrun, 0);
        chk("arst_data", push, 0);
        q.delete();
        n_m = 0; mask_m = '0; last_m = '0; overrun_m = 1'b0;
        fin = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        configure(0, '1);
        tick(1);
        fire(NS'(8'h07), 1);
        wait_done("post_rst", 20, 0);
`ifdef ANALOG_TX_FLIP_COUNT_EN
        chk("post_rst_flip", flip, 3);
`endif
        fin = 1'b0;
        tick(3);
        chk("queue_empty", NS'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
